// File: rtl/mc_ctrl_if.sv
// Control-unit bus: instruction fields and flags in, datapath controls out.
interface mc_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       Overflow;
    logic       MemReady;

    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemToReg;
    logic       ALUSrcA;
    logic       ExtZero;
    logic       Exception;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [3:0] ALUCtrl;

    // Controller side
    modport master (
        input  Op, Funct, Zero, Overflow, MemReady,
        output MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite, RegDst,
               MemToReg, ALUSrcA, ExtZero, Exception, ALUSrcB, PCSrc, ALUCtrl
    );

    // Datapath side
    modport slave (
        output Op, Funct, Zero, Overflow, MemReady,
        input  MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite, RegDst,
               MemToReg, ALUSrcA, ExtZero, Exception, ALUSrcB, PCSrc, ALUCtrl
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller. Outputs are registered from the
// next-state decode so they change cleanly on the clock edge; IRWrite and
// the overflow-suppressed RegWrite are the only input-qualified outputs.
module mc_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    mc_ctrl_if.master    bus
);
    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 4;

    localparam logic [ALU_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_ADDU = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SUBU = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_SLLV = 4'b1010;
    localparam logic [ALU_W-1:0] ALU_SRLV = 4'b1011;
    localparam logic [ALU_W-1:0] ALU_LUI  = 4'b1100;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'b1110;
    localparam logic [ALU_W-1:0] ALU_NOR  = 4'b1111;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [OP_W-1:0] FN_ADD   = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB   = 6'b100010;

    typedef enum logic [3:0] {
        FETCH, PCINC, DECODE, EXEC, WB, MEMADR, MEMRD, MEMWB,
        MEMWR, BREQ, BRDEC, BRTGT, BRUPD, JUMP, EXC
    } state_t;

    // R-type funct -> {legal, alu op}
    function automatic logic [ALU_W:0] r_decode(input logic [OP_W-1:0] fn);
        case (fn)
            6'b100000: return {1'b1, ALU_ADD};
            6'b100001: return {1'b1, ALU_ADDU};
            6'b100010: return {1'b1, ALU_SUB};
            6'b100011: return {1'b1, ALU_SUBU};
            6'b100100: return {1'b1, ALU_AND};
            6'b100101: return {1'b1, ALU_OR};
            6'b100110: return {1'b1, ALU_XOR};
            6'b100111: return {1'b1, ALU_NOR};
            6'b101010: return {1'b1, ALU_SLT};
            6'b101011: return {1'b1, ALU_SLTU};
            6'b000000: return {1'b1, ALU_SLL};
            6'b000010: return {1'b1, ALU_SRL};
            6'b000100: return {1'b1, ALU_SLLV};
            6'b000110: return {1'b1, ALU_SRLV};
            default:   return {1'b0, ALU_AND};
        endcase
    endfunction

    // Immediate opcode -> {legal, zero-extend, alu op}
    function automatic logic [ALU_W+1:0] i_decode(input logic [OP_W-1:0] op);
        case (op)
            6'b001000: return {2'b10, ALU_ADD};
            6'b001001: return {2'b10, ALU_ADDU};
            6'b001010: return {2'b10, ALU_SLT};
            6'b001011: return {2'b10, ALU_SLTU};
            6'b001100: return {2'b11, ALU_AND};
            6'b001101: return {2'b11, ALU_OR};
            6'b001110: return {2'b11, ALU_XOR};
            6'b001111: return {2'b10, ALU_LUI};
            default:   return {2'b00, ALU_AND};
        endcase
    endfunction

    state_t            state, nst;
    logic [OP_W-1:0]   op_q, funct_q;
    logic [ALU_W:0]    r_dec;
    logic [ALU_W+1:0]  i_dec;
    logic              is_rtype;

    logic mem_read_q,  mem_read_d;
    logic mem_write_q, mem_write_d;
    logic iord_q,      iord_d;
    logic irw_en_q,    irw_en_d;
    logic pc_write_q,  pc_write_d;
    logic reg_write_q, reg_write_d;
    logic reg_dst_q,   reg_dst_d;
    logic mem_to_reg_q, mem_to_reg_d;
    logic src_a_q,     src_a_d;
    logic ext_zero_q,  ext_zero_d;
    logic exc_q,       exc_d;
    logic ovf_chk_q,   ovf_chk_d;
    logic [1:0]        src_b_q, src_b_d;
    logic [1:0]        pc_src_q, pc_src_d;
    logic [ALU_W-1:0]  alu_q, alu_d;

    // Next-state selection followed by Moore decode of the next state
    always_comb begin
        nst          = state;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        iord_d       = 1'b0;
        irw_en_d     = 1'b0;
        pc_write_d   = 1'b0;
        reg_write_d  = 1'b0;
        reg_dst_d    = 1'b0;
        mem_to_reg_d = 1'b0;
        src_a_d      = 1'b0;
        ext_zero_d   = 1'b0;
        exc_d        = 1'b0;
        ovf_chk_d    = 1'b0;
        src_b_d      = 2'b00;
        pc_src_d     = 2'b00;
        alu_d        = ALU_AND;

        r_dec    = r_decode(funct_q);
        i_dec    = i_decode(op_q);
        is_rtype = (op_q == OP_RTYPE);

        case (state)
            FETCH:  if (bus.MemReady) nst = PCINC;
            PCINC:  nst = DECODE;
            DECODE: begin
                if (is_rtype)                      nst = r_dec[ALU_W] ? EXEC : EXC;
                else if (i_dec[ALU_W+1])           nst = EXEC;
                else if (op_q == OP_LW || op_q == OP_SW)   nst = MEMADR;
                else if (op_q == OP_BEQ || op_q == OP_BNE) nst = BREQ;
                else if (op_q == OP_J)             nst = JUMP;
                else                               nst = EXC;
            end
            EXEC:   nst = WB;
            WB:     nst = (ovf_chk_q && bus.Overflow) ? EXC : FETCH;
            MEMADR: nst = (op_q == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (bus.MemReady) nst = MEMWB;
            MEMWB:  nst = FETCH;
            MEMWR:  if (bus.MemReady) nst = FETCH;
            BREQ:   nst = BRDEC;
            BRDEC:  nst = ((op_q == OP_BEQ) ? bus.Zero : !bus.Zero) ? BRTGT : FETCH;
            BRTGT:  nst = BRUPD;
            BRUPD:  nst = FETCH;
            JUMP:   nst = FETCH;
            EXC:    nst = FETCH;
            default: nst = FETCH;
        endcase

        case (nst)
            FETCH: begin
                mem_read_d = 1'b1;
                irw_en_d   = 1'b1;
            end
            PCINC: begin
                src_b_d = 2'b01;
                alu_d   = ALU_ADDU;
            end
            DECODE: pc_write_d = 1'b1;
            EXEC: begin
                src_a_d    = 1'b1;
                src_b_d    = is_rtype ? 2'b00 : 2'b10;
                alu_d      = is_rtype ? r_dec[ALU_W-1:0] : i_dec[ALU_W-1:0];
                ext_zero_d = !is_rtype && i_dec[ALU_W];
            end
            WB: begin
                reg_write_d = 1'b1;
                reg_dst_d   = is_rtype;
                ovf_chk_d   = (is_rtype && (funct_q == FN_ADD || funct_q == FN_SUB))
                              || (op_q == OP_ADDI);
            end
            MEMADR: begin
                src_a_d = 1'b1;
                src_b_d = 2'b10;
                alu_d   = ALU_ADDU;
            end
            MEMRD: begin
                iord_d     = 1'b1;
                mem_read_d = 1'b1;
            end
            MEMWB: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            MEMWR: begin
                iord_d      = 1'b1;
                mem_write_d = 1'b1;
            end
            BREQ: begin
                src_a_d = 1'b1;
                alu_d   = ALU_SUBU;
            end
            BRTGT: begin
                src_b_d = 2'b11;
                alu_d   = ALU_ADDU;
            end
            BRUPD: pc_write_d = 1'b1;
            JUMP: begin
                pc_write_d = 1'b1;
                pc_src_d   = 2'b10;
            end
            EXC: begin
                pc_write_d = 1'b1;
                pc_src_d   = 2'b11;
                exc_d      = 1'b1;
            end
            default: ;
        endcase
    end

    // State, instruction latch and registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            op_q         <= '0;
            funct_q      <= '0;
            mem_read_q   <= 1'b1;
            irw_en_q     <= 1'b1;
            mem_write_q  <= 1'b0;
            iord_q       <= 1'b0;
            pc_write_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            src_a_q      <= 1'b0;
            ext_zero_q   <= 1'b0;
            exc_q        <= 1'b0;
            ovf_chk_q    <= 1'b0;
            src_b_q      <= 2'b00;
            pc_src_q     <= 2'b00;
            alu_q        <= ALU_AND;
        end else begin
            state <= nst;
            if (state == FETCH && bus.MemReady) begin
                op_q    <= bus.Op;
                funct_q <= bus.Funct;
            end
            mem_read_q   <= mem_read_d;
            irw_en_q     <= irw_en_d;
            mem_write_q  <= mem_write_d;
            iord_q       <= iord_d;
            pc_write_q   <= pc_write_d;
            reg_write_q  <= reg_write_d;
            reg_dst_q    <= reg_dst_d;
            mem_to_reg_q <= mem_to_reg_d;
            src_a_q      <= src_a_d;
            ext_zero_q   <= ext_zero_d;
            exc_q        <= exc_d;
            ovf_chk_q    <= ovf_chk_d;
            src_b_q      <= src_b_d;
            pc_src_q     <= pc_src_d;
            alu_q        <= alu_d;
        end
    end

    // FETCH-state strobes idle at 1 under reset, so mask them with rst_n
    assign bus.MemRead   = mem_read_q && rst_n;
    assign bus.IRWrite   = irw_en_q && rst_n && bus.MemReady;
    assign bus.RegWrite  = reg_write_q && !(ovf_chk_q && bus.Overflow);
    assign bus.MemWrite  = mem_write_q;
    assign bus.IorD      = iord_q;
    assign bus.PCWrite   = pc_write_q;
    assign bus.RegDst    = reg_dst_q;
    assign bus.MemToReg  = mem_to_reg_q;
    assign bus.ALUSrcA   = src_a_q;
    assign bus.ExtZero   = ext_zero_q;
    assign bus.Exception = exc_q;
    assign bus.ALUSrcB   = src_b_q;
    assign bus.PCSrc     = pc_src_q;
    assign bus.ALUCtrl   = alu_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class state by state.
module tb_mc_ctrl;
    localparam int unsigned OW = 19;

    // Expected output vectors, grouped as
    // {MemRead MemWrite IorD IRWrite}_{PCWrite RegWrite RegDst MemToReg}_
    // {ALUSrcA ExtZero Exception}_ALUSrcB_PCSrc_ALUCtrl
    localparam logic [OW-1:0] E_RST      = 19'b0000_0000_000_00_00_0000;
    localparam logic [OW-1:0] E_FETCH    = 19'b1000_0000_000_00_00_0000;
    localparam logic [OW-1:0] E_FETCH_RD = 19'b1001_0000_000_00_00_0000;
    localparam logic [OW-1:0] E_PCINC    = 19'b0000_0000_000_01_00_0011;
    localparam logic [OW-1:0] E_DECODE   = 19'b0000_1000_000_00_00_0000;
    localparam logic [OW-1:0] E_EX_ADDU  = 19'b0000_0000_100_00_00_0011;
    localparam logic [OW-1:0] E_EX_ADD   = 19'b0000_0000_100_00_00_0010;
    localparam logic [OW-1:0] E_EX_SLLV  = 19'b0000_0000_100_00_00_1010;
    localparam logic [OW-1:0] E_EX_ANDI  = 19'b0000_0000_110_10_00_0000;
    localparam logic [OW-1:0] E_EX_SLTI  = 19'b0000_0000_100_10_00_0110;
    localparam logic [OW-1:0] E_WB_R     = 19'b0000_0110_000_00_00_0000;
    localparam logic [OW-1:0] E_WB_R_OVF = 19'b0000_0010_000_00_00_0000;
    localparam logic [OW-1:0] E_WB_I     = 19'b0000_0100_000_00_00_0000;
    localparam logic [OW-1:0] E_MEMADR   = 19'b0000_0000_100_10_00_0011;
    localparam logic [OW-1:0] E_MEMRD    = 19'b1010_0000_000_00_00_0000;
    localparam logic [OW-1:0] E_MEMWB    = 19'b0000_0101_000_00_00_0000;
    localparam logic [OW-1:0] E_MEMWR    = 19'b0110_0000_000_00_00_0000;
    localparam logic [OW-1:0] E_BREQ     = 19'b0000_0000_100_00_00_0101;
    localparam logic [OW-1:0] E_BRDEC    = 19'b0000_0000_000_00_00_0000;
    localparam logic [OW-1:0] E_BRTGT    = 19'b0000_0000_000_11_00_0011;
    localparam logic [OW-1:0] E_BRUPD    = 19'b0000_1000_000_00_00_0000;
    localparam logic [OW-1:0] E_JUMP     = 19'b0000_1000_000_00_10_0000;
    localparam logic [OW-1:0] E_EXC      = 19'b0000_1000_001_00_11_0000;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OW-1:0] outs();
        return {bus.MemRead, bus.MemWrite, bus.IorD, bus.IRWrite,
                bus.PCWrite, bus.RegWrite, bus.RegDst, bus.MemToReg,
                bus.ALUSrcA, bus.ExtZero, bus.Exception,
                bus.ALUSrcB, bus.PCSrc, bus.ALUCtrl};
    endfunction

    task automatic check(input string tag, input logic [OW-1:0] obs,
                         input logic [OW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in FETCH with memory ready, then scramble the
    // live Op/Funct so later states must rely on the latched copy.
    task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input string tag);
        bus.Op       = op;
        bus.Funct    = fn;
        bus.MemReady = 1'b1;
        #1;
        check(tag, outs(), E_FETCH_RD);
        tick();
        bus.MemReady = 1'b0;
        bus.Op       = 6'b111111;
        bus.Funct    = 6'b111111;
    endtask

    // Common PCINC/DECODE pair after fetch
    task automatic front(input string tag);
        check({tag, "_pcinc"}, outs(), E_PCINC);
        tick();
        check({tag, "_decode"}, outs(), E_DECODE);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        bus.Op       = 6'b0;
        bus.Funct    = 6'b0;
        bus.Zero     = 1'b0;
        bus.Overflow = 1'b0;
        bus.MemReady = 1'b0;

        #2;
        check("reset_low", outs(), E_RST);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release", outs(), E_FETCH);
        tick();
        check("fetch_wait", outs(), E_FETCH);

        // addu: five-cycle R-type path
        fetch(6'b000000, 6'b100001, "addu_fetch");
        front("addu");
        check("addu_exec", outs(), E_EX_ADDU);
        tick();
        check("addu_wb", outs(), E_WB_R);
        tick();
        check("addu_done", outs(), E_FETCH);

        // lw with three wait cycles in MEMRD
        fetch(6'b100011, 6'b000000, "lw_fetch");
        front("lw");
        check("lw_memadr", outs(), E_MEMADR);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("lw_memrd_wait", outs(), E_MEMRD);
            tick();
        end
        bus.MemReady = 1'b1;
        check("lw_memrd_ready", outs(), E_MEMRD);
        tick();
        bus.MemReady = 1'b0;
        check("lw_memwb", outs(), E_MEMWB);
        tick();
        check("lw_done", outs(), E_FETCH);

        // beq taken
        fetch(6'b000100, 6'b000000, "beq_t_fetch");
        front("beq_t");
        check("beq_t_breq", outs(), E_BREQ);
        tick();
        bus.Zero = 1'b1;
        check("beq_t_brdec", outs(), E_BRDEC);
        tick();
        bus.Zero = 1'b0;
        check("beq_t_brtgt", outs(), E_BRTGT);
        tick();
        check("beq_t_brupd", outs(), E_BRUPD);
        tick();
        check("beq_t_done", outs(), E_FETCH);

        // beq not taken: straight back to FETCH with no further PCWrite
        fetch(6'b000100, 6'b000000, "beq_n_fetch");
        front("beq_n");
        check("beq_n_breq", outs(), E_BREQ);
        tick();
        check("beq_n_brdec", outs(), E_BRDEC);
        tick();
        check("beq_n_fetch1", outs(), E_FETCH);
        tick();
        check("beq_n_fetch2", outs(), E_FETCH);

        // bne taken when Zero=0
        fetch(6'b000101, 6'b000000, "bne_fetch");
        front("bne");
        tick();
        check("bne_brdec", outs(), E_BRDEC);
        tick();
        check("bne_brtgt", outs(), E_BRTGT);
        tick();
        tick();
        check("bne_done", outs(), E_FETCH);

        // add with overflow: writeback suppressed, exception taken
        fetch(6'b000000, 6'b100000, "add_fetch");
        front("add");
        check("add_exec", outs(), E_EX_ADD);
        tick();
        bus.Overflow = 1'b1;
        #1;
        check("add_wb_ovf", outs(), E_WB_R_OVF);
        tick();
        bus.Overflow = 1'b0;
        check("add_exc", outs(), E_EXC);
        tick();
        check("add_exc_one", outs(), E_FETCH);

        // addu with overflow: normal writeback
        fetch(6'b000000, 6'b100001, "addu_ovf_fetch");
        front("addu_ovf");
        tick();
        bus.Overflow = 1'b1;
        #1;
        check("addu_ovf_wb", outs(), E_WB_R);
        tick();
        bus.Overflow = 1'b0;
        check("addu_ovf_done", outs(), E_FETCH);

        // Illegal opcode
        fetch(6'b111111, 6'b000000, "ill_op_fetch");
        front("ill_op");
        check("ill_op_exc", outs(), E_EXC);
        tick();
        check("ill_op_done", outs(), E_FETCH);

        // Illegal R-type funct
        fetch(6'b000000, 6'b000001, "ill_fn_fetch");
        front("ill_fn");
        check("ill_fn_exc", outs(), E_EXC);
        tick();

        // sllv
        fetch(6'b000000, 6'b000100, "sllv_fetch");
        front("sllv");
        check("sllv_exec", outs(), E_EX_SLLV);
        tick();
        tick();

        // andi: zero-extended immediate
        fetch(6'b001100, 6'b000000, "andi_fetch");
        front("andi");
        check("andi_exec", outs(), E_EX_ANDI);
        tick();
        check("andi_wb", outs(), E_WB_I);
        tick();

        // slti: sign-extended immediate
        fetch(6'b001010, 6'b000000, "slti_fetch");
        front("slti");
        check("slti_exec", outs(), E_EX_SLTI);
        tick();
        tick();

        // j
        fetch(6'b000010, 6'b000000, "j_fetch");
        front("j");
        check("j_jump", outs(), E_JUMP);
        tick();
        check("j_done", outs(), E_FETCH);

        // sw interrupted by reset during the memory wait
        fetch(6'b101011, 6'b000000, "sw_fetch");
        front("sw");
        check("sw_memadr", outs(), E_MEMADR);
        tick();
        check("sw_memwr", outs(), E_MEMWR);
        tick();
        check("sw_memwr_wait", outs(), E_MEMWR);
        #2;
        rst_n = 1'b0;
        #1;
        check("sw_reset_low", outs(), E_RST);
        tick();
        check("sw_reset_hold", outs(), E_RST);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("sw_reset_release", outs(), E_FETCH);
        tick();
        check("sw_after_reset", outs(), E_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
